// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock referee and its move counters.
package chess_clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    SETUP,
    RUN_A,
    RUN_B,
    PAUSE,
    OVER
  } state_t;

  typedef enum logic {
    SIDE_A,
    SIDE_B
  } side_t;

  // Start-time presets, BCD tens in [7:4], units in [3:0]
  localparam logic [7:0] PRESET [0:7] = '{
    8'h05, 8'h10, 8'h30, 8'h99, 8'h01, 8'h15, 8'h45, 8'h60
  };

endpackage

// File: rtl/chess_move_counter.sv
// Two-digit BCD move counter; clear has priority over increment, 99 wraps to 00.
module chess_move_counter
  import chess_clock_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_inc,
  input  logic           i_clr,
  output bcd_t [1:0]     o_count
);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_inc) begin
      if (o_count[0] == 4'd9) begin
        o_count[0] <= 4'd0;
        o_count[1] <= (o_count[1] == 4'd9) ? 4'd0 : o_count[1] + 4'd1;
      end else begin
        o_count[0] <= o_count[0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/chess_clock_referee.sv
// Game controller for a two-player chess clock: game FSM, preset selection,
// move counting and stop/win/reload control for both player clocks.
module chess_clock_referee
  import chess_clock_pkg::*;
#(
  parameter int p_first   = 0,
  parameter int p_presets = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_preset,
  input  logic       i_turn_a,
  input  logic       i_turn_b,
  input  logic       i_zero_a,
  input  logic       i_zero_b,
  output logic       o_stop_a,
  output logic       o_stop_b,
  output logic       o_win_a,
  output logic       o_win_b,
  output bcd_t [1:0] o_init,
  output logic       o_reload,
  output bcd_t [1:0] o_moves_a,
  output bcd_t [1:0] o_moves_b
);

  localparam state_t     FIRST_RUN = (p_first == 0) ? RUN_A : RUN_B;
  localparam logic [2:0] IDX_LAST  = 3'(p_presets - 1);

  state_t      state, state_nxt;
  side_t       resume_side, resume_side_nxt;
  side_t       winner, winner_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        reload_nxt;
  logic        inc_a, inc_b, clr_moves;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= SETUP;
      resume_side <= SIDE_A;
      winner      <= SIDE_A;
      idx         <= '0;
      o_reload    <= 1'b0;
    end else begin
      state       <= state_nxt;
      resume_side <= resume_side_nxt;
      winner      <= winner_nxt;
      idx         <= idx_nxt;
      o_reload    <= reload_nxt;
    end
  end

  // Flag fall beats pause, pause beats the move click; a flag fall counts no move.
  always_comb begin
    state_nxt       = state;
    resume_side_nxt = resume_side;
    winner_nxt      = winner;
    idx_nxt         = idx;
    reload_nxt      = 1'b0;
    inc_a           = 1'b0;
    inc_b           = 1'b0;
    clr_moves       = 1'b0;
    case (state)
      SETUP: begin
        if (i_start) begin
          state_nxt = FIRST_RUN;
        end else if (i_preset) begin
          idx_nxt = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end
      end
      RUN_A: begin
        if (i_zero_a) begin
          state_nxt  = OVER;
          winner_nxt = SIDE_B;
        end else if (i_pause) begin
          state_nxt       = PAUSE;
          resume_side_nxt = SIDE_A;
        end else if (i_turn_a) begin
          state_nxt = RUN_B;
          inc_a     = 1'b1;
        end
      end
      RUN_B: begin
        if (i_zero_b) begin
          state_nxt  = OVER;
          winner_nxt = SIDE_A;
        end else if (i_pause) begin
          state_nxt       = PAUSE;
          resume_side_nxt = SIDE_B;
        end else if (i_turn_b) begin
          state_nxt = RUN_A;
          inc_b     = 1'b1;
        end
      end
      PAUSE: begin
        if (i_start) begin
          state_nxt  = SETUP;
          reload_nxt = 1'b1;
        end else if (i_pause) begin
          state_nxt = (resume_side == SIDE_A) ? RUN_A : RUN_B;
        end
      end
      OVER: begin
        if (i_start) begin
          state_nxt  = SETUP;
          reload_nxt = 1'b1;
          clr_moves  = 1'b1;
        end
      end
      default: state_nxt = SETUP;
    endcase
  end

  assign o_stop_a = (state != RUN_A);
  assign o_stop_b = (state != RUN_B);
  assign o_win_a  = (state == OVER) && (winner == SIDE_A);
  assign o_win_b  = (state == OVER) && (winner == SIDE_B);
  assign o_init   = PRESET[idx];

  chess_move_counter u_moves_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (inc_a),
    .i_clr   (clr_moves),
    .o_count (o_moves_a)
  );

  chess_move_counter u_moves_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (inc_b),
    .i_clr   (clr_moves),
    .o_count (o_moves_b)
  );

endmodule

// File: tb/tb_chess_clock_referee.sv
// Directed bench for chess_clock_referee: vector table plus multi-cycle sequences.
module tb_chess_clock_referee;
  import chess_clock_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pause, preset, turn_a, turn_b, zero_a, zero_b;
  logic       stop_a, stop_b, win_a, win_b, reload;
  bcd_t [1:0] init, moves_a, moves_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chess_clock_referee #(.p_first(0), .p_presets(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_start   (start),
    .i_pause   (pause),
    .i_preset  (preset),
    .i_turn_a  (turn_a),
    .i_turn_b  (turn_b),
    .i_zero_a  (zero_a),
    .i_zero_b  (zero_b),
    .o_stop_a  (stop_a),
    .o_stop_b  (stop_b),
    .o_win_a   (win_a),
    .o_win_b   (win_b),
    .o_init    (init),
    .o_reload  (reload),
    .o_moves_a (moves_a),
    .o_moves_b (moves_b)
  );

  // Input bits: {start, pause, preset, turn_a, turn_b, zero_a, zero_b}
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] ST = 7'b1000000;
  localparam logic [6:0] PA = 7'b0100000;
  localparam logic [6:0] PR = 7'b0010000;
  localparam logic [6:0] TA = 7'b0001000;
  localparam logic [6:0] TB = 7'b0000100;
  localparam logic [6:0] ZA = 7'b0000010;
  localparam logic [6:0] ZB = 7'b0000001;

  typedef struct {
    logic [6:0] in;
    logic [3:0] flags;   // {stop_a, stop_b, win_a, win_b}
    logic [7:0] init;
    logic       reload;
    logic [7:0] ma;
    logic [7:0] mb;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(logic [6:0] in, logic [3:0] flags, logic [7:0] ini,
                              logic rl, logic [7:0] ma, logic [7:0] mb);
    vec_t v;
    v.in = in; v.flags = flags; v.init = ini; v.reload = rl; v.ma = ma; v.mb = mb;
    return v;
  endfunction

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic drive(input logic [6:0] in);
    {start, pause, preset, turn_a, turn_b, zero_a, zero_b} = in;
    @(posedge clk);
    #1;
    {start, pause, preset, turn_a, turn_b, zero_a, zero_b} = NO;
  endtask

  task automatic chk_all(string tag, logic [3:0] flags, logic [7:0] ini,
                         logic rl, logic [7:0] ma, logic [7:0] mb);
    chk({tag, ".flags"},  {4'h0, stop_a, stop_b, win_a, win_b}, {4'h0, flags});
    chk({tag, ".init"},   {init[1], init[0]}, ini);
    chk({tag, ".reload"}, {7'h0, reload}, {7'h0, rl});
    chk({tag, ".moves_a"}, {moves_a[1], moves_a[0]}, ma);
    chk({tag, ".moves_b"}, {moves_b[1], moves_b[0]}, mb);
  endtask

  initial begin
    vecs[0]  = mk(NO,      4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);
    vecs[1]  = mk(PR,      4'b1100, 8'h10, 1'b0, 8'h00, 8'h00);
    vecs[2]  = mk(PR,      4'b1100, 8'h30, 1'b0, 8'h00, 8'h00);
    vecs[3]  = mk(ST,      4'b0100, 8'h30, 1'b0, 8'h00, 8'h00);
    vecs[4]  = mk(TA,      4'b1000, 8'h30, 1'b0, 8'h01, 8'h00);
    vecs[5]  = mk(TB,      4'b0100, 8'h30, 1'b0, 8'h01, 8'h01);
    vecs[6]  = mk(TA,      4'b1000, 8'h30, 1'b0, 8'h02, 8'h01);
    vecs[7]  = mk(PA,      4'b1100, 8'h30, 1'b0, 8'h02, 8'h01);
    vecs[8]  = mk(TB,      4'b1100, 8'h30, 1'b0, 8'h02, 8'h01);
    vecs[9]  = mk(PA,      4'b1000, 8'h30, 1'b0, 8'h02, 8'h01);
    vecs[10] = mk(TA | ZA, 4'b1000, 8'h30, 1'b0, 8'h02, 8'h01);
    vecs[11] = mk(TB,      4'b0100, 8'h30, 1'b0, 8'h02, 8'h02);
    vecs[12] = mk(TB | ZB, 4'b0100, 8'h30, 1'b0, 8'h02, 8'h02);
    vecs[13] = mk(PR,      4'b0100, 8'h30, 1'b0, 8'h02, 8'h02);
    vecs[14] = mk(ST,      4'b0100, 8'h30, 1'b0, 8'h02, 8'h02);
    vecs[15] = mk(TA | PA, 4'b1100, 8'h30, 1'b0, 8'h02, 8'h02);
    vecs[16] = mk(PA,      4'b0100, 8'h30, 1'b0, 8'h02, 8'h02);
    vecs[17] = mk(TA | ZA, 4'b1101, 8'h30, 1'b0, 8'h02, 8'h02);
    vecs[18] = mk(NO,      4'b1101, 8'h30, 1'b0, 8'h02, 8'h02);
    vecs[19] = mk(ST,      4'b1100, 8'h30, 1'b1, 8'h00, 8'h00);
    vecs[20] = mk(NO,      4'b1100, 8'h30, 1'b0, 8'h00, 8'h00);
    vecs[21] = mk(PR,      4'b1100, 8'h99, 1'b0, 8'h00, 8'h00);
    vecs[22] = mk(PR,      4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);

    {start, pause, preset, turn_a, turn_b, zero_a, zero_b} = NO;
    rst_n = 1'b0;
    #1;
    chk_all("reset", 4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].in);
      chk_all($sformatf("vec%0d", i), vecs[i].flags, vecs[i].init,
              vecs[i].reload, vecs[i].ma, vecs[i].mb);
    end

    // Move counter wrap after 100 accepted turns per side
    drive(ST);
    for (int i = 1; i <= 100; i++) begin
      drive(TA);
      drive(TB);
      if (i == 10) chk_all("wrap10", 4'b0100, 8'h05, 1'b0, 8'h10, 8'h10);
      if (i == 99) chk_all("wrap99", 4'b0100, 8'h05, 1'b0, 8'h99, 8'h99);
    end
    chk_all("wrap100", 4'b0100, 8'h05, 1'b0, 8'h00, 8'h00);

    // B flag falls: A wins, new game reloads for exactly one cycle
    drive(TA);
    drive(ZB);
    chk_all("win_a", 4'b1110, 8'h05, 1'b0, 8'h01, 8'h00);
    drive(ST);
    chk_all("over_start", 4'b1100, 8'h05, 1'b1, 8'h00, 8'h00);
    drive(NO);
    chk_all("reload_once", 4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);

    // Zero beats pause in the same cycle
    drive(ST);
    drive(ZA | PA);
    chk_all("zero_vs_pause", 4'b1101, 8'h05, 1'b0, 8'h00, 8'h00);
    drive(ST);
    drive(NO);

    // New game from pause: reload pulse, clocks stopped
    drive(ST);
    drive(PA);
    chk_all("pause_a", 4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);
    drive(ST);
    chk_all("pause_start", 4'b1100, 8'h05, 1'b1, 8'h00, 8'h00);
    drive(NO);
    chk_all("pause_reload_end", 4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);

    // Asynchronous reset in the middle of RUN_A
    drive(PR);
    drive(ST);
    drive(TA);
    drive(TB);
    chk_all("pre_reset", 4'b0100, 8'h10, 1'b0, 8'h01, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_all("in_reset", 4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(NO);
    chk_all("after_reset", 4'b1100, 8'h05, 1'b0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
